// File: rtl/seg7_pkg.sv
// Shared constants and types for the scanned 7-segment display.
// Segment patterns are {a,b,c,d,e,f,g}, active high.
package seg7_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1111110,
    7'b0110000,
    7'b1101101,
    7'b1111001,
    7'b0110011,
    7'b1011011,
    7'b1011111,
    7'b1110000,
    7'b1111111,
    7'b1111011
  };

  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

endpackage

// File: rtl/seg7_digit_encoder.sv
// BCD nibble to 7-segment pattern; codes 10..15 blank.
// Ports: bcd (4b in), seg (7b out, {a..g}, active high).
module seg7_digit_encoder
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9)
      seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Binary -> BCD (sequential double dabble) with multiplexed 7-seg scan.
// Ports: clk, rst (async high), value/load in, busy/ovf/seg/an out.
// Option: SEG7_LZ_BLANK_EN blanks leading-zero digits (digit 0 kept).
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      value,
  input  logic                  load,
  output logic                  busy,
  output logic                  ovf,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(BIN_W + 1);
  localparam logic [31:0] LIMIT =
    32'(10 ** NUM_DIGITS);

  state_t state, nstate;
  logic ld_en, step_en, commit_en;

  logic [BIN_W-1:0] bin_sr;
  logic [DW-1:0]    acc, acc_adj, disp;
  logic [BW-1:0]    bit_cnt;
  logic             ovf_pend;

  logic [CW-1:0]         scan_cnt;
  logic [IW-1:0]         dig_idx;
  logic [3:0]            nib;
  logic                  lz_blank;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [6:0]            enc_seg, seg_nxt;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // FSM: next state
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:
        if (load) nstate = CONV;
      CONV:
        if (bit_cnt == BW'(BIN_W - 1))
          nstate = COMMIT;
      COMMIT:
        nstate = IDLE;
      default:
        nstate = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state != IDLE);
    ld_en     = (state == IDLE) && load;
    step_en   = (state == CONV);
    commit_en = (state == COMMIT);
  end

  // +3 on every nibble >= 5 ahead of the shift
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sr   <= '0;
      acc      <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
      ovf      <= 1'b0;
    end else begin
      if (ld_en) begin
        bin_sr   <= value;
        acc      <= '0;
        bit_cnt  <= '0;
        ovf_pend <= (32'(value) >= LIMIT);
      end else if (step_en) begin
        // top carry out of acc_adj is dropped
        acc     <= {acc_adj[DW-2:0],
                    bin_sr[BIN_W-1]};
        bin_sr  <= bin_sr << 1;
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (commit_en) begin
        disp <= acc;
        ovf  <= ovf_pend;
      end
    end
  end

  // scan timebase, free running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      if (dig_idx == IW'(NUM_DIGITS - 1))
        dig_idx <= '0;
      else
        dig_idx <= dig_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic run;

  // digit i blank when it and all above are zero
  always_comb begin
    lz_mask = '0;
    run     = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run        = run & (disp[4*i +: 4] == 4'd0);
      lz_mask[i] = run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    nib      = 4'd0;
    lz_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (dig_idx == IW'(i)) begin
        nib      = disp[4*i +: 4];
        lz_blank = lz_mask[i];
      end
  end

  seg7_digit_encoder u_enc (
    .bcd (nib),
    .seg (enc_seg)
  );

  always_comb begin
    seg_nxt = enc_seg;
    if (ovf)
      seg_nxt = SEG_DASH;
    else if (lz_blank)
      seg_nxt = SEG_BLANK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= '0;
      an  <= '0;
    end else begin
      seg <= seg_nxt;
      an  <= NUM_DIGITS'(1) << dig_idx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display (SCAN_DIV=4).
// Honors SEG7_LZ_BLANK_EN in its expected patterns.
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] value;
  logic        load;
  logic        busy;
  logic        ovf;
  logic [6:0]  seg;
  logic [3:0]  an;

  int ncmp  = 0;
  int nfail = 0;

  seg7_scan_display #(
    .NUM_DIGITS (4),
    .BIN_W      (14),
    .SCAN_DIV   (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .busy  (busy),
    .ovf   (ovf),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got=%0h exp=%0h",
             tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pat(int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(int v,
                                         int idx);
    int p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (v >= 10000) return 7'b0000001;
`ifdef SEG7_LZ_BLANK_EN
    if (idx > 0 && v < p) return 7'b0000000;
`endif
    return pat((v / p) % 10);
  endfunction

  // one full scan (16 clk), checking every digit
  task automatic check_scan(input int v);
    int idx;
    for (int e = 0; e < 16; e++) begin
      tick();
      idx = -1;
      for (int i = 0; i < 4; i++)
        if (an == 4'(1 << i)) idx = i;
      chk("an_onehot", 32'(idx >= 0), 32'd1);
      if (idx >= 0)
        chk($sformatf("seg_v%0d_d%0d", v, idx),
            32'(seg), 32'(exp_seg(v, idx)));
      chk("ovf", 32'(ovf), 32'(v >= 10000));
    end
  endtask

  task automatic do_load(input int v,
                         input bit inject);
    int n;
    value = 14'(v);
    load  = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (inject && n == 3) begin
        value = 14'd42;
        load  = 1'b1;
      end
      if (inject && n == 4) load = 1'b0;
      tick();
    end
    chk($sformatf("busy_len_v%0d", v), n, 15);
  endtask

  initial begin
    int nb;
    rst   = 1'b1;
    load  = 1'b0;
    value = '0;

    @(posedge clk);
    #1;
    chk("rst_seg", 32'(seg), 0);
    chk("rst_an", 32'(an), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(ovf), 0);
    tick();
    rst = 1'b0;

    // 4 clk per digit, starting on digit 0
    for (int e = 1; e <= 16; e++) begin
      tick();
      chk($sformatf("an_e%0d", e), 32'(an),
          32'(1 << ((e - 1) / 4)));
      chk($sformatf("seg0_e%0d", e), 32'(seg),
          32'(exp_seg(0, (e - 1) / 4)));
      chk("busy_idle", 32'(busy), 0);
    end

    do_load(1234, 1'b0);
    check_scan(1234);

    do_load(9999, 1'b0);
    check_scan(9999);

    do_load(10000, 1'b0);
    check_scan(10000);

    // reset during conversion
    value = 14'd8888;
    load  = 1'b1;
    tick();
    load = 1'b0;
    repeat (5) tick();
    chk("busy_pre_rst", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_seg", 32'(seg), 0);
    chk("arst_an", 32'(an), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ovf", 32'(ovf), 0);
    tick();
    rst = 1'b0;
    nb = 0;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (busy) nb++;
    end
    chk("no_commit_busy", nb, 0);
    check_scan(0);

    // load during CONV is dropped
    do_load(555, 1'b1);
    nb = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (busy) nb++;
    end
    chk("single_busy", nb, 0);
    check_scan(555);

    do_load(7, 1'b0);
    check_scan(7);

    do_load(0, 1'b0);
    check_scan(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
